sd_spi_responder: RTL and testbench
===================================

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter NCR, default 1: count of 0xFF bytes the responder SHALL send between the last command byte and the R1 byte.
REQ-002 Parameter NAC, default 2: count of 0xFF bytes the responder SHALL send between R1 and the 0xFE start token on CMD17.
REQ-003 Parameter INIT_POLLS, default 2: count of ACMD41s answered 0x01 before the first ACMD41 answered 0x00.
REQ-004 clock  in  1  sole clock; every flop SHALL be clocked on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sclk  in  1  SPI clock from host, mode 0, asynchronous to clock; clock SHALL be at least 8x sclk.
REQ-007 mosi  in  1  host-to-card serial data, MSB first.
REQ-008 ss  in  1  active-low chip select.
REQ-009 miso  out  1  card-to-host serial data, MSB first; SHALL be 1 whenever nothing is being sent.
REQ-010 mem_addr  out  32  byte address of the next data byte to fetch.
REQ-011 mem_rd  out  1  one-cycle fetch strobe.
REQ-012 mem_data  in  8  fetched byte, valid exactly 1 clock after mem_rd.
REQ-013 card_ready  out  1  1 after the initialisation sequence completes (card out of idle).
REQ-014 cmd_strobe  out  1  one-cycle pulse when a full 6-byte command has been received.
REQ-015 cmd_index  out  6  index of the last received command, held until the next one.

Function
REQ-016 sclk, mosi and ss SHALL pass through two-flop synchronisers; rising and falling sclk edges SHALL be detected on the synchronised signal.
REQ-017 With ss low, mosi SHALL be sampled on each synchronised sclk rising edge; miso SHALL change only on the clock after a synchronised sclk falling edge.
REQ-018 In RX_CMD, bytes whose bits [7:6] are not 01 SHALL be discarded; a byte with bits [7:6] = 01 SHALL start a 6-byte command: index, arg[31:24..7:0], CRC.
REQ-019 State sequence: RX_CMD -> NCR -> R1 -> (R7_TAIL | NAC -> TOKEN -> DATA -> DCRC | RX_CMD) -> RX_CMD.
REQ-020 Response byte transmission SHALL start at the first byte boundary after the 6th command byte; 8 sclk cycles SHALL form one byte.
REQ-021 CMD0 SHALL return R1 0x01, set idle, clear the poll count and clear card_ready.
REQ-022 CMD8 SHALL return R1 {7'b0, idle}, then 4 bytes 0x00, 0x00, arg[11:8], arg[7:0] (R7_TAIL).
REQ-023 CMD55 SHALL return R1 {7'b0, idle} and set app_cmd for the next command only.
REQ-024 CMD41 with app_cmd set SHALL return 0x01 and increment the poll count while the count is below INIT_POLLS, else return 0x00, clear idle and set card_ready.
REQ-025 CMD41 without app_cmd, or any other index, SHALL return R1 {5'b0, 1'b1 (illegal), 1'b0, idle}.
REQ-026 CMD17 with idle set SHALL return 0x05 and send no data; with idle clear it SHALL return 0x00, then NAC bytes of 0xFF, then 0xFE, then 512 data bytes, then 2 bytes 0xFF as dummy CRC.
REQ-027 Data byte n (0..511) SHALL come from mem_addr = arg + n, with 32-bit wrap-around; mem_rd SHALL pulse once per byte, at least 2 clocks before that byte's first bit.
REQ-028 The data byte counter SHALL be 10 bits wide; DATA SHALL exit after count 511.
REQ-029 Bytes received on mosi during NCR, R1, R7_TAIL, NAC, TOKEN, DATA and DCRC SHALL be ignored.
REQ-030 ss going high at any point SHALL abort the transfer: back to RX_CMD, bit and byte counters cleared, miso = 1, no mem_rd; idle, poll count and card_ready SHALL be kept.
REQ-031 If ss falls and sclk toggles on the same synchronised cycle, the ss transition SHALL be processed first.

Reset
REQ-032 During reset: state = RX_CMD, miso = 1, mem_rd = 0, mem_addr = 0, cmd_strobe = 0, cmd_index = 0, card_ready = 0, idle = 1, app_cmd = 0, poll count = 0, all counters = 0.
REQ-033 Reset asserted in mid-transfer SHALL take effect on the next clock edge, regardless of sclk or ss.

Configuration
REQ-034 Macro SD_RESP_CRC_CHECK_EN defined: CRC7 (polynomial x^7+x^3+1, initial value 0) SHALL be computed over the 40 command bits; if {crc7, 1'b1} differs from byte 6, R1 SHALL be {4'b0, 1'b1 (CRC error), 2'b0, idle}, no side effects SHALL occur, and no data SHALL be sent.
REQ-035 Macro SD_RESP_CRC_CHECK_EN undefined: byte 6 SHALL be ignored and no CRC logic SHALL be synthesised.

Verification
REQ-036 CMD0 40 00 00 00 00 95 -> after NCR bytes of 0xFF, miso = 0x01; card_ready = 0.
REQ-037 CMD8 48 00 00 01 AA 87 -> response bytes 01 00 00 01 AA.
REQ-038 Two (55, 41 arg 0x40000000) pairs -> R1 0x01 each; third pair -> 0x01 then 0x00, and card_ready = 1.
REQ-039 CMD17 arg 0x00000200 after init, memory byte = address[7:0] -> bytes 00, FF, FF, FE, 00..FF twice, FF, FF; mem_addr runs 0x200..0x3FF.
REQ-040 ss raised after data byte 100 of CMD17, then a new CMD17 -> miso = 1 at once, state = RX_CMD, card_ready still 1, second read complete.
REQ-041 With SD_RESP_CRC_CHECK_EN defined, CMD0 with CRC 0x00 -> R1 0x09 (idle already 1 after reset); without the macro -> R1 0x01.

Source files
------------

// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: answers CMD0/8/17/41/55 and streams 512-byte blocks from a fetch port.
// Optional CRC7 command check is built when SD_RESP_CRC_CHECK_EN is defined.
module sd_spi_responder #(
    parameter int NCR        = 1,
    parameter int NAC        = 2,
    parameter int INIT_POLLS = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ss,
    output logic        miso,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic        card_ready,
    output logic        cmd_strobe,
    output logic [5:0]  cmd_index,
    output logic [2:0]  debug_state
);
    typedef enum logic [2:0] {
        S_RX_CMD, S_NCR, S_R1, S_R7_TAIL, S_NAC, S_TOKEN, S_DATA, S_DCRC
    } state_t;

    // state names the next byte slot to be loaded at a byte boundary.
    state_t      state, state_next;
    logic [9:0]  cnt, cnt_next;
    logic [2:0]  sclk_q;
    logic [1:0]  mosi_q, ss_q;
    logic        active, sclk_rise, sclk_fall, byte_done, cmd_done, boundary;
    logic [2:0]  bit_cnt, cmd_cnt;
    logic [6:0]  rx_sr, tx_sr;
    logic [7:0]  rx_byte, tx_load, r1_q, data_buf;
    logic [37:0] cmd_sr;
    logic [5:0]  cmd_idx;
    logic [31:0] arg_q;
    logic        send_r7, send_data, rd_pend, fetch;
    logic        idle, app_cmd;
    logic [15:0] poll_cnt;
    logic [7:0]  r1_d;
    logic        r7_d, data_d, idle_d, app_d, ready_d, crc_ok;
    logic [15:0] poll_d;

    assign active      = ~ss_q[1];
    assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
    assign rx_byte     = {rx_sr, mosi_q[1]};
    assign byte_done   = active & sclk_rise & (bit_cnt == 3'd7);
    assign cmd_done    = byte_done & (state == S_RX_CMD) & (cmd_cnt == 3'd5);
    assign boundary    = active & sclk_fall & (bit_cnt == 3'd0);
    assign cmd_idx     = cmd_sr[37:32];
    assign debug_state = state;

`ifdef SD_RESP_CRC_CHECK_EN
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
            else             c = {c[5:0], 1'b0};
        end
        return c;
    endfunction
    // Index byte bits [7:6] are always 01 once a command has started.
    assign crc_ok = ({crc7({2'b01, cmd_sr}), 1'b1} == rx_byte);
`else
    assign crc_ok = 1'b1;
`endif

    // Command decode, applied only on the 6th byte of a command.
    always_comb begin
        r1_d    = {5'b0, 1'b1, 1'b0, idle};
        r7_d    = 1'b0;
        data_d  = 1'b0;
        idle_d  = idle;
        app_d   = 1'b0;
        poll_d  = poll_cnt;
        ready_d = card_ready;
        if (!crc_ok) begin
            r1_d  = {4'b0, 1'b1, 2'b0, idle};
            app_d = app_cmd;
        end else begin
            case (cmd_idx)
                6'd0: begin
                    r1_d = 8'h01; idle_d = 1'b1; poll_d = '0; ready_d = 1'b0;
                end
                6'd8:  begin r1_d = {7'b0, idle}; r7_d = 1'b1; end
                6'd55: begin r1_d = {7'b0, idle}; app_d = 1'b1; end
                6'd41: begin
                    if (app_cmd) begin
                        if (poll_cnt < 16'(INIT_POLLS)) begin
                            r1_d = 8'h01; poll_d = poll_cnt + 16'd1;
                        end else begin
                            r1_d = 8'h00; idle_d = 1'b0; ready_d = 1'b1;
                        end
                    end
                end
                6'd17: begin
                    if (idle) r1_d = 8'h05;
                    else begin r1_d = 8'h00; data_d = 1'b1; end
                end
                default: ;
            endcase
        end
    end

    // Next byte slot and the byte loaded into the transmit shifter at a boundary.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        tx_load    = 8'hFF;
        fetch      = 1'b0;
        if (!active) begin
            state_next = S_RX_CMD;
            cnt_next   = '0;
        end else if (cmd_done) begin
            state_next = (NCR == 0) ? S_R1 : S_NCR;
            cnt_next   = '0;
        end else if (boundary) begin
            case (state)
                S_NCR: begin
                    if (cnt == 10'(NCR - 1)) begin state_next = S_R1; cnt_next = '0; end
                    else cnt_next = cnt + 10'd1;
                end
                S_R1: begin
                    tx_load  = r1_q;
                    cnt_next = '0;
                    if (send_r7)        state_next = S_R7_TAIL;
                    else if (send_data) state_next = (NAC == 0) ? S_TOKEN : S_NAC;
                    else                state_next = S_RX_CMD;
                end
                S_R7_TAIL: begin
                    case (cnt[1:0])
                        2'd2:    tx_load = {4'b0, arg_q[11:8]};
                        2'd3:    tx_load = arg_q[7:0];
                        default: tx_load = 8'h00;
                    endcase
                    if (cnt == 10'd3) begin state_next = S_RX_CMD; cnt_next = '0; end
                    else cnt_next = cnt + 10'd1;
                end
                S_NAC: begin
                    if (cnt == 10'(NAC - 1)) begin state_next = S_TOKEN; cnt_next = '0; end
                    else cnt_next = cnt + 10'd1;
                end
                S_TOKEN: begin
                    tx_load    = 8'hFE;
                    state_next = S_DATA;
                    cnt_next   = '0;
                    fetch      = 1'b1;
                end
                S_DATA: begin
                    tx_load = data_buf;
                    if (cnt == 10'd511) begin state_next = S_DCRC; cnt_next = '0; end
                    else begin cnt_next = cnt + 10'd1; fetch = 1'b1; end
                end
                S_DCRC: begin
                    if (cnt == 10'd1) begin state_next = S_RX_CMD; cnt_next = '0; end
                    else cnt_next = cnt + 10'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_RX_CMD;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Fetch port: mem_rd is a one-cycle request for mem_addr; mem_data is taken
    // on the following cycle. Each byte is prefetched one byte slot ahead.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_q <= '0; mosi_q <= '0; ss_q <= 2'b11;
            bit_cnt <= '0; cmd_cnt <= '0; rx_sr <= '0; cmd_sr <= '0;
            tx_sr <= '1; miso <= 1'b1; mem_rd <= 1'b0; rd_pend <= 1'b0;
            mem_addr <= '0; data_buf <= '0; arg_q <= '0; r1_q <= 8'hFF;
            send_r7 <= 1'b0; send_data <= 1'b0; cmd_strobe <= 1'b0; cmd_index <= '0;
            card_ready <= 1'b0; idle <= 1'b1; app_cmd <= 1'b0; poll_cnt <= '0;
        end else begin
            sclk_q     <= {sclk_q[1:0], sclk};
            mosi_q     <= {mosi_q[0], mosi};
            ss_q       <= {ss_q[0], ss};
            cmd_strobe <= 1'b0;
            mem_rd     <= fetch;
            rd_pend    <= mem_rd;
            if (fetch)   mem_addr <= arg_q + 32'(cnt_next);
            if (rd_pend) data_buf <= mem_data;
            if (!active) begin
                bit_cnt <= '0;
                cmd_cnt <= '0;
                miso    <= 1'b1;
                tx_sr   <= '1;
                mem_rd  <= 1'b0;
                rd_pend <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sr   <= rx_byte[6:0];
                end
                if (byte_done && state == S_RX_CMD && (cmd_cnt != 3'd0 || rx_byte[7:6] == 2'b01)) begin
                    if (cmd_cnt == 3'd5) begin
                        cmd_cnt    <= '0;
                        cmd_strobe <= 1'b1;
                        cmd_index  <= cmd_idx;
                        arg_q      <= cmd_sr[31:0];
                        r1_q       <= r1_d;
                        send_r7    <= r7_d;
                        send_data  <= data_d;
                        idle       <= idle_d;
                        app_cmd    <= app_d;
                        poll_cnt   <= poll_d;
                        card_ready <= ready_d;
                    end else begin
                        cmd_cnt <= cmd_cnt + 3'd1;
                        cmd_sr  <= {cmd_sr[29:0], rx_byte};
                    end
                end
                if (boundary) begin
                    miso  <= tx_load[7];
                    tx_sr <= tx_load[6:0];
                end else if (sclk_fall) begin
                    miso  <= tx_sr[6];
                    tx_sr <= {tx_sr[5:0], 1'b1};
                end
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: SPI mode-0 host driver, byte-addressed memory
// model returning address[7:0], and immediate-assertion checks with a final tally.
module tb_sd_spi_responder;
    localparam int H = 5;  // clocks per sclk half-period

    logic        clock = 1'b0;
    logic        reset, sclk, mosi, ss;
    logic        miso, mem_rd, card_ready, cmd_strobe;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;
    logic [5:0]  cmd_index;
    logic [2:0]  debug_state;

    int          checks = 0;
    int          failures = 0;
    int          strobes = 0;
    int          rd_count = 0;
    int          rd_snap;
    logic [31:0] addr_q[$];
    logic [7:0]  b;

    sd_spi_responder dut (
        .clock(clock), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss),
        .miso(miso), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .card_ready(card_ready), .cmd_strobe(cmd_strobe), .cmd_index(cmd_index),
        .debug_state(debug_state)
    );

    always #5 clock = ~clock;

    // Memory model: data valid the cycle after mem_rd, value = address low byte.
    always @(posedge clock) begin
        if (mem_rd) begin
            mem_data <= mem_addr[7:0];
            addr_q.push_back(mem_addr);
            rd_count <= rd_count + 1;
        end
        if (cmd_strobe) strobes <= strobes + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
            else             c = {c[5:0], 1'b0};
        end
        return c;
    endfunction

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (H) @(negedge clock);
            sclk  = 1'b1;
            rx[i] = miso;
            repeat (H) @(negedge clock);
            sclk = 1'b0;
        end
    endtask

    task automatic send_raw(input logic [47:0] c);
        logic [7:0] r;
        for (int i = 5; i >= 0; i--) xfer(c[i*8 +: 8], r);
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] body;
        body = {2'b01, idx, arg};
        send_raw({body, crc7(body), 1'b1});
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] r;
        xfer(8'hFF, r);
        check(tag, {24'h0, r}, {24'h0, exp});
    endtask

    initial begin
        reset = 1'b1; sclk = 1'b0; mosi = 1'b1; ss = 1'b1;
        repeat (4) @(negedge clock);
        check("rst_miso", {31'h0, miso}, 32'h1);
        check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_card_ready", {31'h0, card_ready}, 32'h0);
        check("rst_cmd_strobe", {31'h0, cmd_strobe}, 32'h0);
        check("rst_cmd_index", {26'h0, cmd_index}, 32'h0);
        check("rst_state", {29'h0, debug_state}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        ss = 1'b0;
        repeat (4) @(negedge clock);

        // CMD0: 40 00 00 00 00 95
        send_raw(48'h40_00000000_95);
        expect_byte("cmd0_ncr", 8'hFF);
        expect_byte("cmd0_r1", 8'h01);
        check("cmd0_ready", {31'h0, card_ready}, 32'h0);
        check("cmd0_strobes", strobes, 32'd1);

        // CMD8: 48 00 00 01 AA 87
        send_raw(48'h48_000001AA_87);
        expect_byte("cmd8_ncr", 8'hFF);
        expect_byte("cmd8_r1", 8'h01);
        expect_byte("cmd8_t0", 8'h00);
        expect_byte("cmd8_t1", 8'h00);
        expect_byte("cmd8_t2", 8'h01);
        expect_byte("cmd8_t3", 8'hAA);
        expect_byte("cmd8_idle_bus", 8'hFF);
        check("cmd8_index", {26'h0, cmd_index}, 32'd8);

        // CMD17 while idle: 0x05, no data, no fetch
        send_cmd(6'd17, 32'h0);
        expect_byte("rd_idle_ncr", 8'hFF);
        expect_byte("rd_idle_r1", 8'h05);
        expect_byte("rd_idle_after0", 8'hFF);
        expect_byte("rd_idle_after1", 8'hFF);
        check("rd_idle_no_fetch", rd_count, 32'd0);

        // Initialisation: two polls answered 0x01, third answered 0x00
        for (int p = 0; p < 3; p++) begin
            send_cmd(6'd55, 32'h0);
            expect_byte("cmd55_ncr", 8'hFF);
            expect_byte("cmd55_r1", 8'h01);
            send_cmd(6'd41, 32'h40000000);
            expect_byte("acmd41_ncr", 8'hFF);
            expect_byte("acmd41_r1", (p == 2) ? 8'h00 : 8'h01);
            check("acmd41_ready", {31'h0, card_ready}, (p == 2) ? 32'h1 : 32'h0);
        end
        check("init_index", {26'h0, cmd_index}, 32'd41);

        // Illegal commands after init
        send_cmd(6'd13, 32'h0);
        expect_byte("cmd13_ncr", 8'hFF);
        expect_byte("cmd13_r1", 8'h04);
        send_cmd(6'd41, 32'h40000000);
        expect_byte("cmd41_noapp_ncr", 8'hFF);
        expect_byte("cmd41_noapp_r1", 8'h04);
        send_cmd(6'd8, 32'h000002C5);
        expect_byte("cmd8b_ncr", 8'hFF);
        expect_byte("cmd8b_r1", 8'h00);
        expect_byte("cmd8b_t0", 8'h00);
        expect_byte("cmd8b_t1", 8'h00);
        expect_byte("cmd8b_t2", 8'h02);
        expect_byte("cmd8b_t3", 8'hC5);

        // CMD17 near the top of the address space, aborted after data byte 100
        addr_q.delete();
        send_cmd(6'd17, 32'hFFFFFFC0);
        expect_byte("rda_ncr", 8'hFF);
        expect_byte("rda_r1", 8'h00);
        expect_byte("rda_nac0", 8'hFF);
        expect_byte("rda_nac1", 8'hFF);
        expect_byte("rda_token", 8'hFE);
        for (int n = 0; n <= 100; n++) expect_byte("rda_data", 8'(8'hC0 + n));
        for (int n = 0; n <= 100; n++) check("rda_addr", addr_q[n], 32'hFFFFFFC0 + 32'(n));
        repeat (H) @(negedge clock);
        ss = 1'b1;
        repeat (5) @(negedge clock);
        check("abort_miso", {31'h0, miso}, 32'h1);
        check("abort_state", {29'h0, debug_state}, 32'h0);
        check("abort_ready", {31'h0, card_ready}, 32'h1);
        rd_snap = rd_count;
        repeat (40) @(negedge clock);
        check("abort_no_fetch", rd_count, rd_snap);
        ss = 1'b0;
        repeat (4) @(negedge clock);

        // Full CMD17 at 0x200
        addr_q.delete();
        rd_snap = rd_count;
        send_cmd(6'd17, 32'h00000200);
        expect_byte("rdb_ncr", 8'hFF);
        expect_byte("rdb_r1", 8'h00);
        expect_byte("rdb_nac0", 8'hFF);
        expect_byte("rdb_nac1", 8'hFF);
        expect_byte("rdb_token", 8'hFE);
        for (int n = 0; n < 512; n++) expect_byte("rdb_data", 8'(n));
        expect_byte("rdb_crc0", 8'hFF);
        expect_byte("rdb_crc1", 8'hFF);
        expect_byte("rdb_idle_bus", 8'hFF);
        check("rdb_fetches", rd_count - rd_snap, 32'd512);
        check("rdb_addr_count", addr_q.size(), 32'd512);
        for (int n = 0; n < 512; n++) check("rdb_addr", addr_q[n], 32'h200 + 32'(n));

        // Reset in the middle of a command byte with sclk high
        xfer(8'h48, b);
        mosi = 1'b0;
        repeat (H) @(negedge clock);
        sclk  = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        check("midrst_ready", {31'h0, card_ready}, 32'h0);
        check("midrst_miso", {31'h0, miso}, 32'h1);
        check("midrst_state", {29'h0, debug_state}, 32'h0);
        check("midrst_index", {26'h0, cmd_index}, 32'h0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        reset = 1'b0;
        sclk  = 1'b0;
        repeat (4) @(negedge clock);

        // CMD0 with a bad CRC byte
        send_raw(48'h40_00000000_00);
        expect_byte("badcrc_ncr", 8'hFF);
`ifdef SD_RESP_CRC_CHECK_EN
        expect_byte("badcrc_r1", 8'h09);
`else
        expect_byte("badcrc_r1", 8'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
